leaf_fetch_scheduler: RTL and testbench

//  Round-robin read-request scheduler that refills the LEAF_CNT 512-bit leaf line buffers ahead of the merger tree.

---
 rtl/leaf_fetch_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_leaf_fetch_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_fetch_scheduler.sv
// Round-robin read-request scheduler refilling the per-leaf line buffers of the merger tree.
// Tracks per-leaf address/remaining lines, one burst in flight per leaf, global outstanding cap.
module leaf_fetch_scheduler #(
    parameter int LEAF_CNT        = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_BYTES      = 64,
    parameter int BURST_LEN       = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LID_W           = $clog2(LEAF_CNT),
    parameter int LEN_W           = $clog2(BURST_LEN) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_seq_lines,
    input  logic [LEAF_CNT-1:0]   i_leaf_available,
    output logic                  o_req_valid,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    output logic [LID_W-1:0]      o_req_leaf,
    output logic [LEN_W-1:0]      o_req_len,
    input  logic                  i_req_ready,
    input  logic                  i_resp_done,
    input  logic [LID_W-1:0]      i_resp_leaf,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ARB   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]            r_state;
    logic [LID_W-1:0]      r_idx;
    logic [31:0]           r_seq_lines;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_acc;
    logic [ADDR_WIDTH-1:0] r_addr [LEAF_CNT];
    logic [31:0]           r_rem  [LEAF_CNT];
    logic [LEAF_CNT-1:0]   r_pending;
    logic [OUT_W-1:0]      r_outstanding;
    logic [LID_W-1:0]      r_rr_ptr;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [LID_W-1:0]      r_req_leaf;
    logic [LEN_W-1:0]      r_req_len;
    logic                  r_done;
    logic                  r_err;

    logic                  w_hs;
    logic                  w_resp_ok;
    logic                  w_resp_bad;
    logic [LEAF_CNT-1:0]   w_set_mask;
    logic [LEAF_CNT-1:0]   w_clr_mask;
    logic [LEAF_CNT-1:0]   w_elig;
    logic                  w_any_rem;
    logic                  w_found;
    logic [LID_W-1:0]      w_grant;
    logic [LEN_W-1:0]      w_grant_len;
    logic                  w_can_issue;

    assign w_hs        = (r_state == S_ISSUE) & i_req_ready;
    assign w_resp_ok   = (r_state != S_IDLE) & i_resp_done & r_pending[i_resp_leaf];
    assign w_resp_bad  = (r_state != S_IDLE) & i_resp_done & ~r_pending[i_resp_leaf];
    assign w_set_mask  = w_hs ? (LEAF_CNT'(1) << r_req_leaf) : '0;
    assign w_clr_mask  = w_resp_ok ? (LEAF_CNT'(1) << i_resp_leaf) : '0;
    assign w_can_issue = r_outstanding < OUT_W'(MAX_OUTSTANDING);
    assign w_grant_len = (r_rem[w_grant] < 32'(BURST_LEN)) ? LEN_W'(r_rem[w_grant])
                                                           : LEN_W'(BURST_LEN);

    always_comb begin
        w_elig    = '0;
        w_any_rem = 1'b0;
        for (int n = 0; n < LEAF_CNT; n++) begin
            w_elig[n] = i_leaf_available[n] & ~r_pending[n] & (r_rem[n] != '0);
            w_any_rem = w_any_rem | (r_rem[n] != '0);
        end
    end

    // First eligible leaf at or after the round-robin pointer; index arithmetic wraps.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_rr_ptr;
        for (int k = 0; k < LEAF_CNT; k++) begin
            if (!w_found && w_elig[r_rr_ptr + LID_W'(k)]) begin
                w_found = 1'b1;
                w_grant = r_rr_ptr + LID_W'(k);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_seq_lines   <= '0;
            r_stride      <= '0;
            r_acc         <= '0;
            r_pending     <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_req_addr    <= '0;
            r_req_leaf    <= '0;
            r_req_len     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            for (int n = 0; n < LEAF_CNT; n++) begin
                r_addr[n] <= '0;
                r_rem[n]  <= '0;
            end
        end else begin
            r_done        <= 1'b0;
            r_pending     <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_outstanding <= r_outstanding + OUT_W'(w_hs) - OUT_W'(w_resp_ok);
            if (w_resp_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_seq_lines <= i_seq_lines;
                        r_stride    <= ADDR_WIDTH'(i_seq_lines) * ADDR_WIDTH'(LINE_BYTES);
                        r_acc       <= i_base_addr;
                        r_idx       <= '0;
                        r_state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    // Leaf start addresses by accumulation: base, base+stride, ...
                    r_addr[r_idx] <= r_acc;
                    r_rem[r_idx]  <= r_seq_lines;
                    r_acc         <= r_acc + r_stride;
                    r_idx         <= r_idx + 1'b1;
                    if (r_idx == LID_W'(LEAF_CNT - 1)) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_can_issue && w_found) begin
                        r_req_addr <= r_addr[w_grant];
                        r_req_leaf <= w_grant;
                        r_req_len  <= w_grant_len;
                        r_state    <= S_ISSUE;
                    end else if (!w_any_rem) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_ISSUE: begin
                    if (i_req_ready) begin
                        r_addr[r_req_leaf] <= r_addr[r_req_leaf]
                                              + ADDR_WIDTH'(r_req_len) * ADDR_WIDTH'(LINE_BYTES);
                        r_rem[r_req_leaf]  <= r_rem[r_req_leaf] - 32'(r_req_len);
                        r_rr_ptr           <= r_req_leaf + 1'b1;
                        r_state            <= S_ARB;
                    end
                end
                S_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_valid = (r_state == S_ISSUE);
    assign o_req_addr  = r_req_addr;
    assign o_req_leaf  = r_req_leaf;
    assign o_req_len   = r_req_len;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_leaf_fetch_scheduler.sv
// Scoreboard bench for leaf_fetch_scheduler: default instance plus a 4-leaf BURST_LEN=4 instance.
module tb_leaf_fetch_scheduler;

    typedef struct packed {
        logic [4:0]  leaf;
        logic [31:0] addr;
        logic [2:0]  len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: default parameters
    logic        a_start, a_valid, a_ready, a_resp_done, a_busy, a_done, a_err;
    logic [31:0] a_base, a_seq, a_avail, a_addr;
    logic [4:0]  a_leaf, a_resp_leaf;
    logic [0:0]  a_len;

    leaf_fetch_scheduler u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_base_addr(a_base),
        .i_seq_lines(a_seq), .i_leaf_available(a_avail), .o_req_valid(a_valid),
        .o_req_addr(a_addr), .o_req_leaf(a_leaf), .o_req_len(a_len), .i_req_ready(a_ready),
        .i_resp_done(a_resp_done), .i_resp_leaf(a_resp_leaf), .o_busy(a_busy),
        .o_done(a_done), .o_err(a_err)
    );

    // Instance B: 4 leaves, bursts of up to 4 lines
    logic        b_start, b_valid, b_ready, b_resp_done, b_busy, b_done, b_err;
    logic [31:0] b_base, b_seq, b_addr;
    logic [3:0]  b_avail;
    logic [1:0]  b_leaf, b_resp_leaf;
    logic [2:0]  b_len;

    leaf_fetch_scheduler #(.LEAF_CNT(4), .BURST_LEN(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_base_addr(b_base),
        .i_seq_lines(b_seq), .i_leaf_available(b_avail), .o_req_valid(b_valid),
        .o_req_addr(b_addr), .o_req_leaf(b_leaf), .o_req_len(b_len), .i_req_ready(b_ready),
        .i_resp_done(b_resp_done), .i_resp_leaf(b_resp_leaf), .o_busy(b_busy),
        .o_done(b_done), .o_err(b_err)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   a_hs_cnt   = 0;
    bit   a_auto     = 1'b1;
    int   a_man_cnt  = 0;
    int   a_man_seen = 0;
    logic [4:0] a_man_leaf = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor + responder for A: completes each burst one cycle after its handshake (auto mode)
    // or on demand from the stimulus (manual mode).
    initial begin : mon_a
        logic       hs_prev;
        logic [4:0] prev_leaf;
        exp_t       e;
        hs_prev     = 1'b0;
        prev_leaf   = '0;
        a_resp_done = 1'b0;
        a_resp_leaf = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_resp_done = 1'b0;
                hs_prev     = 1'b0;
                a_man_seen  = a_man_cnt;
            end else begin
                if (a_man_cnt != a_man_seen) begin
                    a_resp_done = 1'b1;
                    a_resp_leaf = a_man_leaf;
                    a_man_seen  = a_man_cnt;
                end else if (a_auto && hs_prev) begin
                    a_resp_done = 1'b1;
                    a_resp_leaf = prev_leaf;
                end else begin
                    a_resp_done = 1'b0;
                end
                hs_prev   = a_valid && a_ready;
                prev_leaf = a_leaf;
                if (a_valid && a_ready) begin
                    a_hs_cnt++;
                    if (qa.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL a_unexpected_req: got leaf %0d addr 0x%0h, expected none",
                                 a_leaf, a_addr);
                    end else begin
                        e = qa.pop_front();
                        check("a_req_leaf", 64'(a_leaf), 64'(e.leaf));
                        check("a_req_addr", 64'(a_addr), 64'(e.addr));
                        check("a_req_len", 64'(a_len), 64'(e.len));
                    end
                end
            end
        end
    end

    initial begin : mon_b
        logic       hs_prev;
        logic [1:0] prev_leaf;
        exp_t       e;
        hs_prev     = 1'b0;
        prev_leaf   = '0;
        b_resp_done = 1'b0;
        b_resp_leaf = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_resp_done = 1'b0;
                hs_prev     = 1'b0;
            end else begin
                b_resp_done = hs_prev;
                b_resp_leaf = prev_leaf;
                hs_prev     = b_valid && b_ready;
                prev_leaf   = b_leaf;
                if (b_valid && b_ready) begin
                    if (qb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL b_unexpected_req: got leaf %0d addr 0x%0h, expected none",
                                 b_leaf, b_addr);
                    end else begin
                        e = qb.pop_front();
                        check("b_req_leaf", 64'(b_leaf), 64'(e.leaf));
                        check("b_req_addr", 64'(b_addr), 64'(e.addr));
                        check("b_req_len", 64'(b_len), 64'(e.len));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int leaf, input int unsigned addr, input int len);
        qa.push_back('{leaf: 5'(leaf), addr: addr, len: 3'(len)});
    endtask

    task automatic push_b(input int leaf, input int unsigned addr, input int len);
        qb.push_back('{leaf: 5'(leaf), addr: addr, len: 3'(len)});
    endtask

    task automatic start_a(input logic [31:0] base, input logic [31:0] seq);
        a_base  = base;
        a_seq   = seq;
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic send_resp_a(input int leaf);
        a_man_leaf = 5'(leaf);
        a_man_cnt++;
        tick(2);
    endtask

    task automatic wait_done_a(input int budget, input string name);
        int  cyc  = 0;
        bit  seen = 1'b0;
        while (cyc < budget && !seen) begin
            @(negedge clk);
            if (a_done) seen = 1'b1;
            cyc++;
        end
        check(name, 64'(seen), 64'd1);
        tick(1);
    endtask

    task automatic wait_hs_a(input int target, input int budget, input string name);
        int cyc = 0;
        while (cyc < budget && a_hs_cnt < target) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 64'(a_hs_cnt), 64'(target));
        tick(1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base_cnt;
        int cyc;
        a_start = 1'b0; a_base = '0; a_seq = '0; a_avail = '1; a_ready = 1'b1;
        b_start = 1'b0; b_base = '0; b_seq = '0; b_avail = 4'hF; b_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_addr", 64'(a_addr), 64'd0);
        check("rst_leaf", 64'(a_leaf), 64'd0);
        check("rst_len", 64'(a_len), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        rst = 1'b0;
        tick(1);

        // Zero-length sequences: INIT -> ARB -> DRAIN -> done, no requests
        base_cnt = a_hs_cnt;
        start_a(32'h1000, 32'd0);
        check("seq0_busy", 64'(a_busy), 64'd1);
        wait_done_a(100, "seq0_done");
        check("seq0_no_req", 64'(a_hs_cnt - base_cnt), 64'd0);
        check("seq0_idle", 64'(a_busy), 64'd0);

        // Full job: 32 leaves x 4 lines, immediate responses
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 32; n++)
                push_a(n, 32'h1000 + n * 32'h100 + k * 32'h40, 1);
        base_cnt = a_hs_cnt;
        start_a(32'h1000, 32'd4);
        wait_done_a(1500, "full_done");
        check("full_done_pulse", 64'(a_done), 64'd0);
        check("full_req_cnt", 64'(a_hs_cnt - base_cnt), 64'd128);
        check("full_queue_empty", 64'(qa.size()), 64'd0);
        check("full_err", 64'(a_err), 64'd0);
        check("full_idle", 64'(a_busy), 64'd0);

        // Only leaf 5 available: one burst in flight at a time
        do_reset();
        a_avail = 32'h0000_0020;
        a_auto  = 1'b0;
        base_cnt = a_hs_cnt;
        start_a(32'h2000, 32'd3);
        for (int k = 0; k < 3; k++) begin
            push_a(5, 32'h2000 + 5 * 32'hC0 + k * 32'h40, 1);
            wait_hs_a(base_cnt + k + 1, 100, "leaf5_grant");
            tick(6);
            check("leaf5_waits_resp", 64'(a_hs_cnt - base_cnt), 64'(k + 1));
            check("leaf5_no_valid", 64'(a_valid), 64'd0);
            send_resp_a(5);
        end
        tick(5);
        check("leaf5_total", 64'(a_hs_cnt - base_cnt), 64'd3);
        check("leaf5_still_busy", 64'(a_busy), 64'd1);
        check("leaf5_err", 64'(a_err), 64'd0);

        // Backpressure: request held stable while i_req_ready is low
        do_reset();
        a_avail = '1;
        a_auto  = 1'b1;
        a_ready = 1'b0;
        start_a(32'h1000, 32'd4);
        cyc = 0;
        while (cyc < 100 && !a_valid) begin
            tick(1);
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 64'(a_valid), 64'd1);
            check("hold_addr", 64'(a_addr), 64'h1000);
            check("hold_leaf", 64'(a_leaf), 64'd0);
            tick(1);
        end
        base_cnt = a_hs_cnt;
        push_a(0, 32'h1000, 1);
        a_ready = 1'b1;
        tick(1);
        a_ready = 1'b0;
        tick(4);
        check("release_one_grant", 64'(a_hs_cnt - base_cnt), 64'd1);
        check("next_valid", 64'(a_valid), 64'd1);
        check("next_leaf", 64'(a_leaf), 64'd1);
        check("next_addr", 64'(a_addr), 64'h1100);

        // Reset while a request is presented
        rst = 1'b1;
        tick(1);
        check("midrst_valid", 64'(a_valid), 64'd0);
        check("midrst_busy", 64'(a_busy), 64'd0);
        check("midrst_addr", 64'(a_addr), 64'd0);
        rst = 1'b0;
        a_ready = 1'b1;
        tick(1);

        // Outstanding cap, then spurious response
        a_auto = 1'b0;
        base_cnt = a_hs_cnt;
        for (int n = 0; n < 8; n++) push_a(n, n * 32'h100, 1);
        start_a(32'h0, 32'd4);
        tick(32 + 40);
        check("cap_req_cnt", 64'(a_hs_cnt - base_cnt), 64'd8);
        check("cap_stall_valid", 64'(a_valid), 64'd0);
        check("cap_busy", 64'(a_busy), 64'd1);
        push_a(8, 32'h800, 1);
        send_resp_a(3);
        tick(10);
        check("cap_one_more", 64'(a_hs_cnt - base_cnt), 64'd9);
        check("cap_err_clean", 64'(a_err), 64'd0);
        send_resp_a(3);
        tick(10);
        check("spur_err", 64'(a_err), 64'd1);
        check("spur_no_new_req", 64'(a_hs_cnt - base_cnt), 64'd9);
        tick(5);
        check("spur_err_sticky", 64'(a_err), 64'd1);
        do_reset();
        check("err_cleared", 64'(a_err), 64'd0);
        check("a_queue_empty", 64'(qa.size()), 64'd0);

        // Instance B: seq_lines=6, BURST_LEN=4 -> len 4 then len 2 per leaf
        for (int r = 0; r < 2; r++)
            for (int n = 0; n < 4; n++)
                push_b(n, n * 32'h180 + r * 32'h100, (r == 0) ? 4 : 2);
        b_base  = 32'h0;
        b_seq   = 32'd6;
        b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
        cyc = 0;
        while (cyc < 500 && !b_done) begin
            @(negedge clk);
            cyc++;
        end
        check("b_done", 64'(b_done), 64'd1);
        tick(1);
        check("b_queue_empty", 64'(qb.size()), 64'd0);
        check("b_err", 64'(b_err), 64'd0);
        check("b_idle", 64'(b_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
